// File: rtl/kalman_pkg.sv
// Kalman scheduler shared types and constants.
// One-hot sequencer states, fixed-point defaults, slice helper.
package kalman_pkg;

  localparam int FRAC_DEF = 16;
  localparam int P_INIT = 1 << FRAC_DEF;

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_INIT = 4'b0010,
    S_FC   = 4'b0100,
    S_UP   = 4'b1000
  } state_t;

  function automatic int lo(input int ch, input int w);
    return ch * w;
  endfunction

endpackage

// File: rtl/kalman_state_bank.sv
// Per-channel Kalman state bank: angle, bias and P 2x2.
// One write port, one combinational read port.
module kalman_state_bank
  import kalman_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DW = 32,
  parameter int FRAC = FRAC_DEF,
  parameter int CW = 1
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic [CW-1:0] wr_ch,
  input  logic          we,
  input  logic          bias_only,
  input  logic [DW-1:0] wr_angle,
  input  logic [DW-1:0] wr_bias,
  input  logic [DW-1:0] wr_p00,
  input  logic [DW-1:0] wr_p01,
  input  logic [DW-1:0] wr_p10,
  input  logic [DW-1:0] wr_p11,
  input  logic [CW-1:0] rd_ch,
  output logic [DW-1:0] rd_angle,
  output logic [DW-1:0] rd_bias,
  output logic [DW-1:0] rd_p00,
  output logic [DW-1:0] rd_p01,
  output logic [DW-1:0] rd_p10,
  output logic [DW-1:0] rd_p11
);

  localparam logic [DW-1:0] P_ONE = DW'(1) << FRAC;

  logic [DW-1:0] angle_q [NUM_CH];
  logic [DW-1:0] bias_q  [NUM_CH];
  logic [DW-1:0] p00_q   [NUM_CH];
  logic [DW-1:0] p01_q   [NUM_CH];
  logic [DW-1:0] p10_q   [NUM_CH];
  logic [DW-1:0] p11_q   [NUM_CH];

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        angle_q[i] <= '0;
        bias_q[i]  <= '0;
        p00_q[i]   <= P_ONE;
        p01_q[i]   <= '0;
        p10_q[i]   <= '0;
        p11_q[i]   <= P_ONE;
      end
    end else if (we) begin
      bias_q[wr_ch] <= wr_bias;
      if (!bias_only) begin
        angle_q[wr_ch] <= wr_angle;
        p00_q[wr_ch]   <= wr_p00;
        p01_q[wr_ch]   <= wr_p01;
        p10_q[wr_ch]   <= wr_p10;
        p11_q[wr_ch]   <= wr_p11;
      end
    end
  end

  assign rd_angle = angle_q[rd_ch];
  assign rd_bias  = bias_q[rd_ch];
  assign rd_p00   = p00_q[rd_ch];
  assign rd_p01   = p01_q[rd_ch];
  assign rd_p10   = p10_q[rd_ch];
  assign rd_p11   = p11_q[rd_ch];

endmodule

// File: rtl/kalman_axis_scheduler.sv
// N-channel Kalman sequencer feeding a shared forecast/update datapath.
// Owns the FSM, step watchdog, overrun and deferred-calibration logic.
module kalman_axis_scheduler
  import kalman_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DW = 32,
  parameter int FRAC = FRAC_DEF,
  parameter int BIAS_W = 16,
  parameter int BIAS_RECIP = 1998,
  parameter int TIMEOUT = 1023,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_in,
  input  logic                     rst_n,
  input  logic [NUM_CH*DW-1:0]     meas_angle_in,
  input  logic [NUM_CH*DW-1:0]     gyro_in,
  input  logic                     sample_vld_in,
  input  logic [NUM_CH*BIAS_W-1:0] gyro_bias_in,
  input  logic                     calib_done_in,
  input  logic                     forecast_done_in,
  input  logic                     update_done_in,
  input  logic [DW-1:0]            angle_t_in,
  input  logic [DW-1:0]            bias_t_in,
  input  logic [DW-1:0]            P_0_0_t_in,
  input  logic [DW-1:0]            P_0_1_t_in,
  input  logic [DW-1:0]            P_1_0_t_in,
  input  logic [DW-1:0]            P_1_1_t_in,
  input  logic                     err_clr_in,
  output logic                     forecast_en_out,
  output logic                     update_en_out,
  output logic [CW-1:0]            ch_out,
  output logic [DW-1:0]            gyro_out,
  output logic [DW-1:0]            new_angle_out,
  output logic [DW-1:0]            angle_t_1_out,
  output logic [DW-1:0]            bias_t_1_out,
  output logic [DW-1:0]            P_0_0_t_1_out,
  output logic [DW-1:0]            P_0_1_t_1_out,
  output logic [DW-1:0]            P_1_0_t_1_out,
  output logic [DW-1:0]            P_1_1_t_1_out,
  output logic [DW-1:0]            angle_opt_out,
  output logic                     opt_vld_out,
  output logic [CW-1:0]            opt_ch_out,
  output logic                     busy_out,
  output logic                     err_timeout_out,
  output logic                     err_overrun_out
);

  localparam int WW = $clog2(TIMEOUT + 1);
  localparam int PW = DW + BIAS_W + 1;
  localparam logic [DW-1:0] P_ONE = DW'(1) << FRAC;
  localparam logic [CW-1:0] LAST = CW'(NUM_CH - 1);
  localparam logic [WW-1:0] WD_MAX = WW'(TIMEOUT - 1);

  state_t state, state_nx;
  logic [CW-1:0] ch, ch_nx;
  logic [WW-1:0] wd;
  logic [NUM_CH*DW-1:0] meas_q, gyro_q;
  logic [NUM_CH*BIAS_W-1:0] cal_bias, pend_bias;
  logic cal_pend;
  logic cal_go, smp_go, smp_drop, fc_go;
  logic commit, to_evt, adv, last, wd_hit;
  logic bank_we, bias_only, load_xp;
  logic signed [PW-1:0] raw_x;
  logic [DW-1:0] bias_cal, wr_bias;
  logic [DW-1:0] rd_angle, rd_bias;
  logic [DW-1:0] rd_p00, rd_p01, rd_p10, rd_p11;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ch <= '0;
    end else begin
      state <= state_nx;
      ch <= ch_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ch_nx = ch;
    cal_go = 1'b0;
    smp_go = 1'b0;
    fc_go = 1'b0;
    commit = 1'b0;
    to_evt = 1'b0;
    bank_we = 1'b0;
    bias_only = 1'b0;
    last = (ch == LAST);
    wd_hit = (wd == WD_MAX);
    unique case (1'b1)
      (state == S_IDLE): begin
        if (calib_done_in || cal_pend) begin
          cal_go = 1'b1;
          state_nx = S_INIT;
          ch_nx = '0;
        end else if (sample_vld_in) begin
          smp_go = 1'b1;
          state_nx = S_FC;
          ch_nx = '0;
        end
      end
      (state == S_INIT): begin
        bank_we = 1'b1;
        bias_only = 1'b1;
        ch_nx = last ? '0 : ch + 1'b1;
        if (last) state_nx = S_IDLE;
      end
      (state == S_FC): begin
        if (forecast_done_in) begin
          fc_go = 1'b1;
          state_nx = S_UP;
        end else if (wd_hit) begin
          to_evt = 1'b1;
        end
      end
      (state == S_UP): begin
        if (update_done_in) begin
          commit = 1'b1;
          bank_we = 1'b1;
        end else if (wd_hit) begin
          to_evt = 1'b1;
        end
      end
      default: ;
    endcase
    adv = commit || to_evt;
    if (adv) begin
      ch_nx = last ? '0 : ch + 1'b1;
      state_nx = last ? S_IDLE : S_FC;
    end
  end

  assign smp_drop = sample_vld_in && !smp_go;
  assign load_xp = smp_go || (adv && !last);

  // Sign-extend the raw LSB bias, scale to Q deg/s, keep the low DW bits.
  assign raw_x = PW'($signed(cal_bias[lo(int'(ch), BIAS_W) +: BIAS_W]));
  assign bias_cal = DW'(raw_x * PW'(BIAS_RECIP));
  assign wr_bias = bias_only ? bias_cal : bias_t_in;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
      meas_q <= '0;
      gyro_q <= '0;
      cal_bias <= '0;
      pend_bias <= '0;
      cal_pend <= 1'b0;
      gyro_out <= '0;
      new_angle_out <= '0;
      angle_t_1_out <= '0;
      bias_t_1_out <= '0;
      P_0_0_t_1_out <= P_ONE;
      P_0_1_t_1_out <= '0;
      P_1_0_t_1_out <= '0;
      P_1_1_t_1_out <= P_ONE;
      angle_opt_out <= '0;
      opt_vld_out <= 1'b0;
      opt_ch_out <= '0;
      err_timeout_out <= 1'b0;
      err_overrun_out <= 1'b0;
    end else begin
      opt_vld_out <= commit;
      if (smp_go || fc_go || load_xp) wd <= '0;
      else if (state == S_FC || state == S_UP) wd <= wd + 1'b1;
      else wd <= '0;
      if (smp_go) begin
        meas_q <= meas_angle_in;
        gyro_q <= gyro_in;
        gyro_out <= gyro_in[DW-1:0];
      end
      // A second calib while one is already queued is ignored.
      if (cal_go) begin
        cal_bias <= cal_pend ? pend_bias : gyro_bias_in;
        cal_pend <= 1'b0;
      end else if (calib_done_in && state != S_IDLE && !cal_pend) begin
        cal_pend <= 1'b1;
        pend_bias <= gyro_bias_in;
      end
      if (load_xp) begin
        angle_t_1_out <= rd_angle;
        bias_t_1_out <= rd_bias;
        P_0_0_t_1_out <= rd_p00;
        P_0_1_t_1_out <= rd_p01;
        P_1_0_t_1_out <= rd_p10;
        P_1_1_t_1_out <= rd_p11;
      end
      if (adv && !last)
        gyro_out <= gyro_q[lo(int'(ch_nx), DW) +: DW];
      if (fc_go)
        new_angle_out <= meas_q[lo(int'(ch), DW) +: DW];
      if (commit) begin
        angle_opt_out <= angle_t_in;
        opt_ch_out <= ch;
      end
      if (to_evt) err_timeout_out <= 1'b1;
      else if (err_clr_in) err_timeout_out <= 1'b0;
      if (smp_drop) err_overrun_out <= 1'b1;
      else if (err_clr_in) err_overrun_out <= 1'b0;
    end
  end

  assign forecast_en_out = (state == S_FC);
  assign update_en_out = (state == S_UP);
  assign busy_out = (state != S_IDLE);
  assign ch_out = ch;

  kalman_state_bank #(
    .NUM_CH(NUM_CH),
    .DW(DW),
    .FRAC(FRAC),
    .CW(CW)
  ) u_bank (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .wr_ch(ch),
    .we(bank_we),
    .bias_only(bias_only),
    .wr_angle(angle_t_in),
    .wr_bias(wr_bias),
    .wr_p00(P_0_0_t_in),
    .wr_p01(P_0_1_t_in),
    .wr_p10(P_1_0_t_in),
    .wr_p11(P_1_1_t_in),
    .rd_ch(ch_nx),
    .rd_angle(rd_angle),
    .rd_bias(rd_bias),
    .rd_p00(rd_p00),
    .rd_p01(rd_p01),
    .rd_p10(rd_p10),
    .rd_p11(rd_p11)
  );

endmodule

// File: tb/tb_kalman_axis_scheduler.sv
// Directed bench for kalman_axis_scheduler, NUM_CH=2, TIMEOUT=15.
// Expected values are hand-computed constants.
module tb_kalman_axis_scheduler;

  localparam int N = 2;
  localparam int DW = 32;
  localparam int BW = 16;
  localparam int TO = 15;

  logic clk_in = 1'b0;
  logic rst_n = 1'b1;
  logic [N*DW-1:0] meas_angle_in, gyro_in;
  logic [N*BW-1:0] gyro_bias_in;
  logic sample_vld_in, calib_done_in;
  logic forecast_done_in, update_done_in, err_clr_in;
  logic [DW-1:0] angle_t_in, bias_t_in;
  logic [DW-1:0] P_0_0_t_in, P_0_1_t_in, P_1_0_t_in, P_1_1_t_in;
  logic forecast_en_out, update_en_out;
  logic [0:0] ch_out, opt_ch_out;
  logic [DW-1:0] gyro_out, new_angle_out, angle_t_1_out, bias_t_1_out;
  logic [DW-1:0] P_0_0_t_1_out, P_0_1_t_1_out;
  logic [DW-1:0] P_1_0_t_1_out, P_1_1_t_1_out;
  logic [DW-1:0] angle_opt_out;
  logic opt_vld_out, busy_out, err_timeout_out, err_overrun_out;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_in = ~clk_in;

  kalman_axis_scheduler #(
    .NUM_CH(N), .DW(DW), .FRAC(16), .BIAS_W(BW),
    .BIAS_RECIP(1998), .TIMEOUT(TO)
  ) dut (
    .clk_in(clk_in),
    .rst_n(rst_n),
    .meas_angle_in(meas_angle_in),
    .gyro_in(gyro_in),
    .sample_vld_in(sample_vld_in),
    .gyro_bias_in(gyro_bias_in),
    .calib_done_in(calib_done_in),
    .forecast_done_in(forecast_done_in),
    .update_done_in(update_done_in),
    .angle_t_in(angle_t_in),
    .bias_t_in(bias_t_in),
    .P_0_0_t_in(P_0_0_t_in),
    .P_0_1_t_in(P_0_1_t_in),
    .P_1_0_t_in(P_1_0_t_in),
    .P_1_1_t_in(P_1_1_t_in),
    .err_clr_in(err_clr_in),
    .forecast_en_out(forecast_en_out),
    .update_en_out(update_en_out),
    .ch_out(ch_out),
    .gyro_out(gyro_out),
    .new_angle_out(new_angle_out),
    .angle_t_1_out(angle_t_1_out),
    .bias_t_1_out(bias_t_1_out),
    .P_0_0_t_1_out(P_0_0_t_1_out),
    .P_0_1_t_1_out(P_0_1_t_1_out),
    .P_1_0_t_1_out(P_1_0_t_1_out),
    .P_1_1_t_1_out(P_1_1_t_1_out),
    .angle_opt_out(angle_opt_out),
    .opt_vld_out(opt_vld_out),
    .opt_ch_out(opt_ch_out),
    .busy_out(busy_out),
    .err_timeout_out(err_timeout_out),
    .err_overrun_out(err_overrun_out)
  );

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [DW-1:0] obs,
                     input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pulse_fc();
    tick(4);
    forecast_done_in = 1'b1;
    tick();
    forecast_done_in = 1'b0;
  endtask

  task automatic pulse_up(input logic [DW-1:0] a, b,
                          input logic [DW-1:0] p00, p01,
                          input logic [DW-1:0] p10, p11);
    tick(4);
    angle_t_in = a;
    bias_t_in = b;
    P_0_0_t_in = p00;
    P_0_1_t_in = p01;
    P_1_0_t_in = p10;
    P_1_1_t_in = p11;
    update_done_in = 1'b1;
    tick();
    update_done_in = 1'b0;
  endtask

  initial begin
    meas_angle_in = '0;
    gyro_in = '0;
    gyro_bias_in = '0;
    sample_vld_in = 1'b0;
    calib_done_in = 1'b0;
    forecast_done_in = 1'b0;
    update_done_in = 1'b0;
    err_clr_in = 1'b0;
    angle_t_in = '0;
    bias_t_in = '0;
    P_0_0_t_in = '0;
    P_0_1_t_in = '0;
    P_1_0_t_in = '0;
    P_1_1_t_in = '0;
    #2 rst_n = 1'b0;
    tick(3);
    chk("rst_p00", P_0_0_t_1_out, 32'h0001_0000);
    chk("rst_p11", P_1_1_t_1_out, 32'h0001_0000);
    chk("rst_p01", P_0_1_t_1_out, 32'h0);
    chk("rst_angle", angle_t_1_out, 32'h0);
    chk("rst_busy", DW'(busy_out), 32'h0);
    chk("rst_fcen", DW'(forecast_en_out), 32'h0);
    chk("rst_ch", DW'(ch_out), 32'h0);
    chk("rst_opt", angle_opt_out, 32'h0);
    rst_n = 1'b1;
    tick();

    // calibration: ch1=-33, ch0=328
    gyro_bias_in = {16'hFFDF, 16'd328};
    calib_done_in = 1'b1;
    tick();
    calib_done_in = 1'b0;
    chk("cal_busy0", DW'(busy_out), 32'h1);
    chk("cal_ch0", DW'(ch_out), 32'h0);
    tick();
    chk("cal_busy1", DW'(busy_out), 32'h1);
    chk("cal_ch1", DW'(ch_out), 32'h1);
    tick();
    chk("cal_idle", DW'(busy_out), 32'h0);

    // pass 1
    meas_angle_in = {32'h0002_8000, 32'h0001_4000};
    gyro_in = {32'h0000_0300, 32'h0000_0200};
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("p1_fcen", DW'(forecast_en_out), 32'h1);
    chk("p1_ch0", DW'(ch_out), 32'h0);
    chk("p1_gyro0", gyro_out, 32'h0000_0200);
    chk("p1_bias0", bias_t_1_out, 32'd655344);
    chk("p1_ang0", angle_t_1_out, 32'h0);
    pulse_fc();
    chk("p1_upen", DW'(update_en_out), 32'h1);
    chk("p1_fcoff", DW'(forecast_en_out), 32'h0);
    chk("p1_meas0", new_angle_out, 32'h0001_4000);
    pulse_up(32'h0001_2000, 32'h111, 32'h0002_0000,
             32'h5, 32'h6, 32'h0003_0000);
    chk("p1_vld0", DW'(opt_vld_out), 32'h1);
    chk("p1_optch0", DW'(opt_ch_out), 32'h0);
    chk("p1_opt0", angle_opt_out, 32'h0001_2000);
    chk("p1_ch1", DW'(ch_out), 32'h1);
    chk("p1_fcen1", DW'(forecast_en_out), 32'h1);
    chk("p1_gyro1", gyro_out, 32'h0000_0300);
    chk("p1_bias1", bias_t_1_out, 32'hFFFE_FE72);
    chk("p1_p00_1", P_0_0_t_1_out, 32'h0001_0000);
    pulse_fc();
    chk("p1_meas1", new_angle_out, 32'h0002_8000);
    pulse_up(32'h0003_4000, 32'h222, 32'h0002_1000,
             32'h7, 32'h8, 32'h0003_1000);
    chk("p1_vld1", DW'(opt_vld_out), 32'h1);
    chk("p1_optch1", DW'(opt_ch_out), 32'h1);
    chk("p1_opt1", angle_opt_out, 32'h0003_4000);
    chk("p1_idle", DW'(busy_out), 32'h0);
    tick();
    chk("p1_vldoff", DW'(opt_vld_out), 32'h0);

    // pass 2: ch0 watchdog
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("p2_ang0", angle_t_1_out, 32'h0001_2000);
    chk("p2_bias0", bias_t_1_out, 32'h111);
    chk("p2_p01", P_0_1_t_1_out, 32'h5);
    chk("p2_p10", P_1_0_t_1_out, 32'h6);
    chk("p2_p11", P_1_1_t_1_out, 32'h0003_0000);
    tick(TO - 1);
    chk("to_pre", DW'(err_timeout_out), 32'h0);
    chk("to_pre_ch", DW'(ch_out), 32'h0);
    tick();
    chk("to_set", DW'(err_timeout_out), 32'h1);
    chk("to_ch1", DW'(ch_out), 32'h1);
    chk("to_novld", DW'(opt_vld_out), 32'h0);
    chk("to_ang1", angle_t_1_out, 32'h0003_4000);
    chk("to_p00_1", P_0_0_t_1_out, 32'h0002_1000);
    pulse_fc();
    pulse_up(32'h0003_5000, 32'h223, 32'h0002_2000,
             32'h9, 32'hA, 32'h0003_2000);
    chk("p2_vld1", DW'(opt_vld_out), 32'h1);
    chk("p2_optch1", DW'(opt_ch_out), 32'h1);
    chk("p2_idle", DW'(busy_out), 32'h0);
    tick();

    // pass 3: overrun in UPDATE, calib during FORECAST
    meas_angle_in = {32'h0002_9000, 32'h0001_5000};
    gyro_in = {32'h0000_0301, 32'h0000_0201};
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("p3_ang0", angle_t_1_out, 32'h0001_2000);
    chk("p3_p00", P_0_0_t_1_out, 32'h0002_0000);
    pulse_fc();
    meas_angle_in = {32'hDEAD_0000, 32'hBEEF_0000};
    gyro_in = {32'h0000_0999, 32'h0000_0888};
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("ov_set", DW'(err_overrun_out), 32'h1);
    chk("ov_upen", DW'(update_en_out), 32'h1);
    pulse_up(32'h0001_3000, 32'h112, 32'h0002_0100,
             32'h5, 32'h6, 32'h0003_0100);
    chk("p3_gyro1", gyro_out, 32'h0000_0301);
    chk("p3_ang1", angle_t_1_out, 32'h0003_5000);
    gyro_bias_in = {16'h0001, 16'hFFFF};
    calib_done_in = 1'b1;
    tick();
    calib_done_in = 1'b0;
    gyro_bias_in = '0;
    chk("pc_stay", DW'(forecast_en_out), 32'h1);
    tick(3);
    forecast_done_in = 1'b1;
    tick();
    forecast_done_in = 1'b0;
    chk("p3_meas1", new_angle_out, 32'h0002_9000);
    pulse_up(32'h0003_6000, 32'h224, 32'h0002_3000,
             32'hB, 32'hC, 32'h0003_3000);
    chk("p3_vld1", DW'(opt_vld_out), 32'h1);
    chk("p3_idle", DW'(busy_out), 32'h0);
    tick();
    chk("pc_init", DW'(busy_out), 32'h1);
    chk("pc_ch0", DW'(ch_out), 32'h0);
    tick();
    chk("pc_ch1", DW'(ch_out), 32'h1);
    tick();
    chk("pc_idle", DW'(busy_out), 32'h0);
    chk("to_sticky", DW'(err_timeout_out), 32'h1);
    chk("ov_sticky", DW'(err_overrun_out), 32'h1);
    err_clr_in = 1'b1;
    tick();
    err_clr_in = 1'b0;
    chk("clr_to", DW'(err_timeout_out), 32'h0);
    chk("clr_ov", DW'(err_overrun_out), 32'h0);

    // pass 4: new bias, dual done, set-over-clear, reset
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("p4_bias0", bias_t_1_out, 32'hFFFF_F832);
    chk("p4_ang0", angle_t_1_out, 32'h0001_3000);
    forecast_done_in = 1'b1;
    update_done_in = 1'b1;
    tick();
    forecast_done_in = 1'b0;
    update_done_in = 1'b0;
    chk("dual_upen", DW'(update_en_out), 32'h1);
    chk("dual_novld", DW'(opt_vld_out), 32'h0);
    chk("dual_ch", DW'(ch_out), 32'h0);
    sample_vld_in = 1'b1;
    err_clr_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    err_clr_in = 1'b0;
    chk("set_wins", DW'(err_overrun_out), 32'h1);
    rst_n = 1'b0;
    #2;
    chk("mid_busy", DW'(busy_out), 32'h0);
    chk("mid_upen", DW'(update_en_out), 32'h0);
    chk("mid_p00", P_0_0_t_1_out, 32'h0001_0000);
    chk("mid_ov", DW'(err_overrun_out), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();

    // pass 5: bank back at reset values
    sample_vld_in = 1'b1;
    tick();
    sample_vld_in = 1'b0;
    chk("p5_fcen", DW'(forecast_en_out), 32'h1);
    chk("p5_bias0", bias_t_1_out, 32'h0);
    chk("p5_ang0", angle_t_1_out, 32'h0);
    tick(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
